// File: rtl/tinker_io_ports.sv
// Multi-channel buffered I/O controller for the Tinker core: per-channel input/output FIFOs.
// Optional stall timeout is enabled by defining TINKER_IO_TIMEOUT_EN.
module tinker_io_ports #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [4:0]                    req_port,
    input  logic [DATA_W-1:0]             req_data,
    output logic                          resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic                          resp_error,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data
);
    localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                r_state, w_state_next;
    logic                  r_write;
    logic [4:0]            r_port;
    logic [DATA_W-1:0]     r_data;
    logic [DATA_W-1:0]     r_resp_data, w_resp_data_next;
    logic                  r_resp_error, w_resp_error_next;

    logic                  w_write;
    logic [4:0]            w_port;
    logic [DATA_W-1:0]     w_data;
    logic [PORT_W-1:0]     w_idx;
    logic                  w_legal;
    logic                  w_active;
    logic                  w_core_push;
    logic                  w_core_pop;
    logic                  w_timeout;

    logic [NUM_PORTS-1:0]             w_in_empty;
    logic [NUM_PORTS-1:0]             w_out_full;
    logic [NUM_PORTS-1:0]             w_in_push, w_in_pop, w_out_push, w_out_pop;
    logic [NUM_PORTS-1:0][DATA_W-1:0] w_in_head;

    // In IDLE the live request is decided on directly; in WAIT the latched copy is retried.
    assign w_write  = (r_state == StIdle) ? req_write : r_write;
    assign w_port   = (r_state == StIdle) ? req_port  : r_port;
    assign w_data   = (r_state == StIdle) ? req_data  : r_data;
    assign w_idx    = w_port[PORT_W-1:0];
    assign w_legal  = ({27'd0, w_port} < NUM_PORTS);
    assign w_active = ((r_state == StIdle) && req_valid) || (r_state == StWait);

    assign w_core_push = w_active && w_legal && w_write && !w_out_full[w_idx];
    assign w_core_pop  = w_active && w_legal && !w_write && !w_in_empty[w_idx];

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = (r_state == StResp);
    assign resp_data  = r_resp_data;
    assign resp_error = r_resp_error;

`ifdef TINKER_IO_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state != StWait) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + TO_W'(1);
        end
    end

    assign w_timeout = (r_state == StWait) && (r_wait_cnt == TO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_write      <= 1'b0;
            r_port       <= '0;
            r_data       <= '0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_resp_data  <= w_resp_data_next;
            r_resp_error <= w_resp_error_next;
            if ((r_state == StIdle) && req_valid) begin
                r_write <= req_write;
                r_port  <= req_port;
                r_data  <= req_data;
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_resp_data_next  = r_resp_data;
        w_resp_error_next = r_resp_error;
        unique case (r_state)
            StIdle, StWait: begin
                if (w_active) begin
                    if (!w_legal || w_timeout) begin
                        w_state_next      = StResp;
                        w_resp_data_next  = '0;
                        w_resp_error_next = 1'b1;
                    end else if (w_core_push) begin
                        w_state_next      = StResp;
                        w_resp_data_next  = '0;
                        w_resp_error_next = 1'b0;
                    end else if (w_core_pop) begin
                        w_state_next      = StResp;
                        w_resp_data_next  = w_in_head[w_idx];
                        w_resp_error_next = 1'b0;
                    end else begin
                        w_state_next = StWait;
                    end
                end
            end
            StResp: begin
                w_state_next      = StIdle;
                w_resp_data_next  = '0;
                w_resp_error_next = 1'b0;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
        logic [DATA_W-1:0] r_in_mem  [DEPTH];
        logic [DATA_W-1:0] r_out_mem [DEPTH];
        logic [PTR_W-1:0]  r_in_wr, r_in_rd, r_out_wr, r_out_rd;
        logic [CNT_W-1:0]  r_in_cnt, r_out_cnt;

        // Full/empty use registered counts only, so a same-cycle pop never frees a slot.
        assign in_ready[g]   = (r_in_cnt != CNT_W'(DEPTH));
        assign w_in_empty[g] = (r_in_cnt == '0);
        assign w_out_full[g] = (r_out_cnt == CNT_W'(DEPTH));
        assign out_valid[g]  = (r_out_cnt != '0);

        assign w_in_push[g]  = in_valid[g] && in_ready[g];
        assign w_in_pop[g]   = w_core_pop && (w_idx == PORT_W'(g));
        assign w_out_push[g] = w_core_push && (w_idx == PORT_W'(g));
        assign w_out_pop[g]  = out_valid[g] && out_ready[g];

        assign w_in_head[g] = r_in_mem[r_in_rd];
        assign out_data[g*DATA_W +: DATA_W] = out_valid[g] ? r_out_mem[r_out_rd] : '0;

        always_ff @(posedge clk) begin
            if (w_in_push[g]) begin
                r_in_mem[r_in_wr] <= in_data[g*DATA_W +: DATA_W];
            end
            if (w_out_push[g]) begin
                r_out_mem[r_out_wr] <= w_data;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_in_wr   <= '0;
                r_in_rd   <= '0;
                r_in_cnt  <= '0;
                r_out_wr  <= '0;
                r_out_rd  <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_in_push[g])  r_in_wr  <= r_in_wr + PTR_W'(1);
                if (w_in_pop[g])   r_in_rd  <= r_in_rd + PTR_W'(1);
                if (w_out_push[g]) r_out_wr <= r_out_wr + PTR_W'(1);
                if (w_out_pop[g])  r_out_rd <= r_out_rd + PTR_W'(1);
                r_in_cnt  <= r_in_cnt + CNT_W'(w_in_push[g]) - CNT_W'(w_in_pop[g]);
                r_out_cnt <= r_out_cnt + CNT_W'(w_out_push[g]) - CNT_W'(w_out_pop[g]);
            end
        end
    end

endmodule

// File: tb/tb_tinker_io_ports.sv
// Self-checking bench for tinker_io_ports: directed scenarios followed by random traffic,
// all compared against a queue-based transaction model.
module tb_tinker_io_ports;
    localparam int DW  = 64;
    localparam int NP  = 4;
    localparam int DEP = 4;
    localparam int TO  = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid, req_ready, req_write;
    logic [4:0]         req_port;
    logic [DW-1:0]      req_data;
    logic               resp_valid, resp_error;
    logic [DW-1:0]      resp_data;
    logic [NP-1:0]      in_valid, in_ready, out_valid, out_ready;
    logic [NP*DW-1:0]   in_data, out_data;

    tinker_io_ports #(
        .DATA_W    (DW),
        .NUM_PORTS (NP),
        .DEPTH     (DEP),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_port   (req_port),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_error (resp_error),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction model: one queue per FIFO plus the outstanding core request.
    logic [DW-1:0] in_q  [NP][$];
    logic [DW-1:0] out_q [NP][$];
    bit            m_busy, m_show, m_write, m_exp_err;
    logic [4:0]    m_port;
    logic [DW-1:0] m_data, m_exp_data;
    int            m_wcnt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NP; c++) begin
            in_q[c].delete();
            out_q[c].delete();
        end
        m_busy = 0;
        m_show = 0;
        m_wcnt = 0;
    endtask

    task automatic tick();
        bit [NP-1:0]   ipush, opop, exp_ir, exp_ov;
        logic [DW-1:0] idat [NP];
        logic [NP*DW-1:0] exp_od;
        bit            cpush, cpop, just;
        int            p;
        cpush = 0;
        cpop  = 0;
        just  = 0;
        p     = 0;
        for (int c = 0; c < NP; c++) begin
            ipush[c] = in_valid[c] && (in_q[c].size() < DEP);
            opop[c]  = out_ready[c] && (out_q[c].size() > 0);
            idat[c]  = in_data[c*DW +: DW];
        end
        if (m_show) begin
            m_show = 0;
            m_busy = 0;
        end else begin
            if (!m_busy && req_valid) begin
                m_busy  = 1;
                just    = 1;
                m_write = req_write;
                m_port  = req_port;
                m_data  = req_data;
            end
            if (m_busy) begin
                p = int'(m_port);
                if (p >= NP) begin
                    m_show = 1; m_exp_err = 1; m_exp_data = '0;
                end else if (m_write && out_q[p].size() < DEP) begin
                    m_show = 1; m_exp_err = 0; m_exp_data = '0; cpush = 1;
                end else if (!m_write && in_q[p].size() > 0) begin
                    m_show = 1; m_exp_err = 0; m_exp_data = in_q[p][0]; cpop = 1;
`ifdef TINKER_IO_TIMEOUT_EN
                end else if (!just && m_wcnt == TO - 1) begin
                    m_show = 1; m_exp_err = 1; m_exp_data = '0;
`endif
                end else begin
                    m_wcnt = just ? 0 : m_wcnt + 1;
                end
            end
        end
        @(posedge clk);
        if (cpop) void'(in_q[p].pop_front());
        for (int c = 0; c < NP; c++) begin
            if (opop[c]) void'(out_q[c].pop_front());
            if (ipush[c]) in_q[c].push_back(idat[c]);
        end
        if (cpush) out_q[p].push_back(m_data);
        #1;
        for (int c = 0; c < NP; c++) begin
            exp_ir[c] = in_q[c].size() < DEP;
            exp_ov[c] = out_q[c].size() > 0;
            exp_od[c*DW +: DW] = exp_ov[c] ? out_q[c][0] : '0;
        end
        chk("req_ready", req_ready, !m_busy);
        chk("resp_valid", resp_valid, m_show);
        if (m_show) begin
            chk("resp_data", resp_data, m_exp_data);
            chk("resp_error", resp_error, m_exp_err);
        end
        chk("in_ready", in_ready, exp_ir);
        chk("out_valid", out_valid, exp_ov);
        for (int c = 0; c < NP; c++) chk("out_data", out_data[c*DW +: DW], exp_od[c*DW +: DW]);
    endtask

    task automatic core(input bit w, input logic [4:0] p, input logic [DW-1:0] d);
        req_valid = 1;
        req_write = w;
        req_port  = p;
        req_data  = d;
        tick();
        req_valid = 0;
    endtask

    initial begin
        reset = 0; req_valid = 0; req_write = 0; req_port = '0; req_data = '0;
        in_valid = '0; in_data = '0; out_ready = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_ready", req_ready, 1);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_data", resp_data, 0);
        chk("rst resp_error", resp_error, 0);
        chk("rst in_ready", in_ready, 4'hF);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data[DW-1:0] | out_data[NP*DW-1:DW], 0);
        #2 reset = 1;

        // Write port 2, hold it until the consumer takes it.
        core(1, 5'd2, 64'hDEAD_BEEF);
        chk("wr resp_valid", resp_valid, 1);
        chk("wr resp_error", resp_error, 0);
        chk("wr out_data2", out_data[2*DW +: DW], 64'hDEAD_BEEF);
        tick();
        chk("wr resp pulse", resp_valid, 0);
        repeat (2) tick();
        chk("wr held", out_valid[2], 1);
        out_ready[2] = 1;
        tick();
        out_ready[2] = 0;
        chk("wr drained", out_valid[2], 0);

        // External pushes 5,6,7 on channel 1 then ordered core reads.
        for (int v = 5; v <= 7; v++) begin
            in_valid[1] = 1;
            in_data[DW +: DW] = DW'(v);
            tick();
        end
        in_valid[1] = 0;
        for (int v = 5; v <= 7; v++) begin
            core(0, 5'd1, '0);
            chk("rd data", resp_data, DW'(v));
            tick();
        end
        core(0, 5'd1, '0);
        chk("rd4 stall", resp_valid, 0);
        tick();
        chk("rd4 req_ready", req_ready, 0);
        in_valid[1] = 1;
        in_data[DW +: DW] = 64'd8;
        tick();
        in_valid[1] = 0;
        chk("rd4 not yet", resp_valid, 0);
        tick();
        chk("rd4 done", resp_valid, 1);
        chk("rd4 data", resp_data, 64'd8);
        tick();

        // Illegal port.
        core(0, 5'd4, '0);
        chk("ill error", resp_error, 1);
        chk("ill data", resp_data, 0);
        tick();

        // Fill out FIFO 0, fifth write blocks until one slot is freed.
        for (int i = 0; i < DEP; i++) begin
            core(1, 5'd0, DW'(100 + i));
            tick();
        end
        core(1, 5'd0, 64'd200);
        chk("full stall", resp_valid, 0);
        tick();
        chk("full req_ready", req_ready, 0);
        out_ready[0] = 1;
        tick();
        out_ready[0] = 0;
        chk("full same cycle", resp_valid, 0);
        tick();
        chk("full done", resp_valid, 1);
        chk("full head", out_data[DW-1:0], 64'd101);
        tick();

`ifdef TINKER_IO_TIMEOUT_EN
        core(0, 5'd3, '0);
        repeat (TO - 1) begin
            tick();
            chk("to early", resp_valid, 0);
        end
        tick();
        chk("to valid", resp_valid, 1);
        chk("to error", resp_error, 1);
        tick();
`endif

        // Reset while a read waits on empty port 3.
        core(0, 5'd3, '0);
        tick();
        chk("pre-rst wait", req_ready, 0);
        #2 reset = 0;
        #1;
        chk("arst req_ready", req_ready, 1);
        chk("arst resp_valid", resp_valid, 0);
        chk("arst in_ready", in_ready, 4'hF);
        chk("arst out_valid", out_valid, 0);
        chk("arst out_data0", out_data[DW-1:0], 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst no resp", resp_valid, 0);
        #2 reset = 1;
        core(1, 5'd3, 64'hABC);
        chk("post-rst resp", resp_valid, 1);
        chk("post-rst data3", out_data[3*DW +: DW], 64'hABC);
        tick();

        // Random concurrent traffic.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = NP'($urandom);
            out_ready = NP'($urandom);
            for (int c = 0; c < NP; c++) in_data[c*DW +: DW] = {$urandom, $urandom};
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_port  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(4, 31))
                                                     : 5'($urandom_range(0, NP - 1));
            req_data  = {$urandom, $urandom};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
